// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, instruction-memory handshake,
// IF/ID pipeline register and a one-word skid buffer for ID stalls.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_pcsrc,
    input  logic [31:0] MEM_btgt,
    input  logic        ID_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] ID_ir,
    output logic [31:0] ID_npc,
    output logic        ID_valid
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        BUF  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] skid_ir;
    logic [31:0] skid_npc;

    // Wraps naturally modulo 2^32.
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // Fetch FSM. A redirect wins over everything: it flushes IF/ID, drops
    // the skid word and any data returned this cycle. imem_req is a flop
    // so it only rises in REQ and never combinationally from inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            ID_ir    <= NOP_IR;
            ID_npc   <= 32'h0;
            ID_valid <= 1'b0;
            skid_ir  <= 32'h0;
            skid_npc <= 32'h0;
            imem_req <= 1'b0;
        end else if (MEM_pcsrc) begin
            state    <= REQ;
            pc       <= MEM_btgt & ~32'h3;
            ID_ir    <= NOP_IR;
            ID_valid <= 1'b0;
            skid_ir  <= 32'h0;
            skid_npc <= 32'h0;
            imem_req <= 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ready && !ID_stall) begin
                        ID_ir    <= imem_rdata;
                        ID_npc   <= pc_plus4;
                        ID_valid <= 1'b1;
                        pc       <= pc_plus4;
                    end else if (imem_ready && ID_stall) begin
                        // ID is busy: park the word, stop fetching.
                        skid_ir  <= imem_rdata;
                        skid_npc <= pc_plus4;
                        pc       <= pc_plus4;
                        state    <= BUF;
                        imem_req <= 1'b0;
                    end else if (!ID_stall) begin
                        // Memory not ready: insert a bubble, keep npc.
                        ID_ir    <= NOP_IR;
                        ID_valid <= 1'b0;
                    end
                end
                BUF: begin
                    if (!ID_stall) begin
                        ID_ir    <= skid_ir;
                        ID_npc   <= skid_npc;
                        ID_valid <= 1'b1;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch. Instruction memory is a combinational model:
// 0x0 -> 0x20010001, 0x4 -> 0x20020002, any other address A -> 0x10000000|A.
module tb_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_pcsrc;
    logic [31:0] MEM_btgt;
    logic        ID_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] ID_ir;
    logic [31:0] ID_npc;
    logic        ID_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(32'h0), .NOP_IR(NOP)) dut (
        .clk(clk), .rst(rst), .MEM_pcsrc(MEM_pcsrc), .MEM_btgt(MEM_btgt),
        .ID_stall(ID_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .ID_ir(ID_ir),
        .ID_npc(ID_npc), .ID_valid(ID_valid)
    );

    always_comb begin
        if (imem_addr == 32'h0)      imem_rdata = 32'h2001_0001;
        else if (imem_addr == 32'h4) imem_rdata = 32'h2002_0002;
        else                         imem_rdata = 32'h1000_0000 | imem_addr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full visible state after an edge.
    task automatic expect_all(input string tag, input logic [31:0] ir, input logic [31:0] npc,
                              input logic vld, input logic [31:0] addr, input logic req);
        chk({tag, ".ir"},   ID_ir, ir);
        chk({tag, ".npc"},  ID_npc, npc);
        chk({tag, ".vld"},  {31'h0, ID_valid}, {31'h0, vld});
        chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".req"},  {31'h0, imem_req}, {31'h0, req});
    endtask

    initial begin
        rst = 1'b1; MEM_pcsrc = 1'b0; MEM_btgt = 32'h0; ID_stall = 1'b0; imem_ready = 1'b1;
        tick();
        expect_all("rst0", NOP, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        expect_all("rst1", NOP, 32'h0, 1'b0, 32'h0, 1'b0);

        // BOOT -> REQ, no IF/ID change
        rst = 1'b0;
        tick();
        expect_all("boot", NOP, 32'h0, 1'b0, 32'h0, 1'b1);

        // Back-to-back fetch
        tick();
        expect_all("f0", 32'h2001_0001, 32'h4, 1'b1, 32'h4, 1'b1);
        tick();
        expect_all("f1", 32'h2002_0002, 32'h8, 1'b1, 32'h8, 1'b1);

        // Stall 3 cycles at PC 0x8: word buffered, IF/ID held, no fetch in BUF
        ID_stall = 1'b1;
        tick();
        expect_all("st0", 32'h2002_0002, 32'h8, 1'b1, 32'hC, 1'b0);
        tick();
        expect_all("st1", 32'h2002_0002, 32'h8, 1'b1, 32'hC, 1'b0);
        tick();
        expect_all("st2", 32'h2002_0002, 32'h8, 1'b1, 32'hC, 1'b0);
        ID_stall = 1'b0;
        tick();
        expect_all("rel", 32'h1000_0008, 32'hC, 1'b1, 32'hC, 1'b1);
        tick();
        expect_all("f3", 32'h1000_000C, 32'h10, 1'b1, 32'h10, 1'b1);

        // Redirect while in BUF with stall held: buffered word discarded
        ID_stall = 1'b1;
        tick();
        expect_all("buf2", 32'h1000_000C, 32'h10, 1'b1, 32'h14, 1'b0);
        MEM_pcsrc = 1'b1; MEM_btgt = 32'h0000_0103;
        tick();
        expect_all("redir", NOP, 32'h10, 1'b0, 32'h100, 1'b1);
        MEM_pcsrc = 1'b0; ID_stall = 1'b0;
        tick();
        expect_all("tgt", 32'h1000_0100, 32'h104, 1'b1, 32'h104, 1'b1);

        // Two not-ready cycles: bubbles, PC and npc held
        imem_ready = 1'b0;
        tick();
        expect_all("bub0", NOP, 32'h104, 1'b0, 32'h104, 1'b1);
        tick();
        expect_all("bub1", NOP, 32'h104, 1'b0, 32'h104, 1'b1);
        imem_ready = 1'b1;
        tick();
        expect_all("resume", 32'h1000_0104, 32'h108, 1'b1, 32'h108, 1'b1);

        // Not ready while stalled: everything held
        imem_ready = 1'b0; ID_stall = 1'b1;
        tick();
        expect_all("hold", 32'h1000_0104, 32'h108, 1'b1, 32'h108, 1'b1);
        imem_ready = 1'b1; ID_stall = 1'b0;

        // Redirect to the top word: PC+4 wraps to 0
        MEM_pcsrc = 1'b1; MEM_btgt = 32'hFFFF_FFFC;
        tick();
        expect_all("top", NOP, 32'h108, 1'b0, 32'hFFFF_FFFC, 1'b1);
        MEM_pcsrc = 1'b0;
        tick();
        expect_all("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 1'b1);
        tick();
        expect_all("f_after", 32'h2001_0001, 32'h4, 1'b1, 32'h4, 1'b1);

        // Reset in the middle of a BUF stall
        ID_stall = 1'b1;
        tick();
        expect_all("buf3", 32'h2001_0001, 32'h4, 1'b1, 32'h8, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        expect_all("rstbuf", NOP, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0; ID_stall = 1'b0;
        tick();
        expect_all("boot2", NOP, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        expect_all("f_rst", 32'h2001_0001, 32'h4, 1'b1, 32'h4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
